envelope_generator: RTL

Per-channel ADSR amplitude envelope and sample scaler. Sits directly downstream of the channel controller and phase/waveform path. The controller's envelope load/enable strobes start and release notes, and the frame tick advances the envelope. The raw 9-bit waveform sample is multiplied by the current envelope level to produce the channel's output sample for the mixer.

---
 rtl/envelope_generator.sv | 135 +++++++++++++
 1 files changed

// File: rtl/envelope_generator.sv
// Per-channel ADSR envelope: steps level on frame ticks, and scales the raw
// waveform sample by the current level with one cycle of latency.
module envelope_generator (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tick_stb,
  input  logic       i_load,
  input  logic       i_release,
  input  logic [7:0] i_attack_rate,
  input  logic [7:0] i_decay_rate,
  input  logic [7:0] i_sustain_level,
  input  logic [7:0] i_release_rate,
  input  logic [8:0] i_sample,
  input  logic       i_sample_valid,
  output logic [7:0] o_level,
  output logic [2:0] o_state,
  output logic       o_active,
  output logic [8:0] o_sample,
  output logic       o_sample_valid
);

  localparam int unsigned LW  = 8;
  localparam int unsigned SW  = 9;
  localparam int unsigned PW  = 18;
  localparam int unsigned STW = 3;

  localparam logic [STW-1:0] ST_IDLE    = 3'd0;
  localparam logic [STW-1:0] ST_ATTACK  = 3'd1;
  localparam logic [STW-1:0] ST_DECAY   = 3'd2;
  localparam logic [STW-1:0] ST_SUSTAIN = 3'd3;
  localparam logic [STW-1:0] ST_RELEASE = 3'd4;

  localparam logic [LW-1:0] LVL_MAX = '1;

  logic [STW-1:0] state_q, state_d;
  logic [LW-1:0]  level_q, level_d;
  logic [LW-1:0]  atk_q, atk_d;
  logic [LW-1:0]  dcy_q, dcy_d;
  logic [LW-1:0]  sus_q, sus_d;
  logic [LW-1:0]  rel_q, rel_d;
  logic           active_q, active_d;
  logic [SW-1:0]  sample_q, sample_d;
  logic           sval_q, sval_d;

  logic [LW:0]          att_sum_c;
  logic [LW-1:0]        dec_sub_c;
  logic [LW-1:0]        rel_sub_c;
  logic signed [PW-1:0] product_c;

  // Saturating arithmetic helpers; subtractions clamp at zero instead of wrapping.
  assign att_sum_c = {1'b0, level_q} + {1'b0, atk_q};
  assign dec_sub_c = (level_q > dcy_q) ? level_q - dcy_q : '0;
  assign rel_sub_c = (level_q > rel_q) ? level_q - rel_q : '0;
  assign product_c = PW'($signed(i_sample)) * PW'($signed({1'b0, level_q}));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      level_q  <= '0;
      atk_q    <= '0;
      dcy_q    <= '0;
      sus_q    <= '0;
      rel_q    <= '0;
      active_q <= 1'b0;
      sample_q <= '0;
      sval_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      atk_q    <= atk_d;
      dcy_q    <= dcy_d;
      sus_q    <= sus_d;
      rel_q    <= rel_d;
      active_q <= active_d;
      sample_q <= sample_d;
      sval_q   <= sval_d;
    end
  end

  // Strobe priority: load, then release (only from a sounding phase), then tick.
  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    atk_d    = atk_q;
    dcy_d    = dcy_q;
    sus_d    = sus_q;
    rel_d    = rel_q;
    sample_d = sample_q;
    sval_d   = i_sample_valid;

    if (i_sample_valid) begin
      sample_d = product_c[16:8];
    end

    if (i_load) begin
      atk_d   = i_attack_rate;
      dcy_d   = i_decay_rate;
      sus_d   = i_sustain_level;
      rel_d   = i_release_rate;
      state_d = ST_ATTACK;
    end else if (i_release && (state_q == ST_ATTACK || state_q == ST_DECAY ||
                               state_q == ST_SUSTAIN)) begin
      state_d = ST_RELEASE;
    end else if (i_tick_stb) begin
      case (state_q)
        ST_ATTACK: begin
          if (atk_q == '0 || att_sum_c[LW]) level_d = LVL_MAX;
          else                              level_d = att_sum_c[LW-1:0];
          if (level_d == LVL_MAX) state_d = ST_DECAY;
        end
        ST_DECAY: begin
          // A level already below sustain is pulled up to it.
          if (dcy_q == '0 || dec_sub_c <= sus_q) level_d = sus_q;
          else                                   level_d = dec_sub_c;
          if (level_d == sus_q) state_d = ST_SUSTAIN;
        end
        ST_RELEASE: begin
          if (rel_q == '0) level_d = '0;
          else             level_d = rel_sub_c;
          if (level_d == '0) state_d = ST_IDLE;
        end
        default: ;
      endcase
    end

    active_d = (state_d != ST_IDLE);
  end

  assign o_level        = level_q;
  assign o_state        = state_q;
  assign o_active       = active_q;
  assign o_sample       = sample_q;
  assign o_sample_valid = sval_q;

endmodule
